// File: rtl/wait_timer_pkg.sv
// Shared definitions for the waiting-time meter: state encodings, BCD digit width, time constants.
// Latency: n/a (types, constants and a constant helper function only).
// Backpressure: n/a.
package wait_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRACE = 2'd1,
        ST_BILL  = 2'd2,
        ST_FULL  = 2'd3
    } wait_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int SEC_PER_MIN = 60;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wait_timer_bcd_mmss_cnt.sv
// BCD MM:SS up-counter, +1 s per cycle with inc high, saturating at 99:59, synchronous clear.
// Latency: outputs change on the clock edge that samples inc.
// Backpressure: none; inc is a single-cycle enable and is never refused.
module bcd_mmss_cnt
    import wait_timer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    output logic [2*BCD_DIGIT_W-1:0]   min_bcd,
    output logic [2*BCD_DIGIT_W-1:0]   sec_bcd
);

    bcd_digit_t sec_lo_q, sec_lo_d;
    bcd_digit_t sec_hi_q, sec_hi_d;
    bcd_digit_t min_lo_q, min_lo_d;
    bcd_digit_t min_hi_q, min_hi_d;
    logic       at_max;

    assign at_max = (min_hi_q == 4'd9) && (min_lo_q == 4'd9) &&
                    (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);

    // Digit ripple: each digit rolls only when all lower digits are at their top value.
    always_comb begin
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        if (inc && !at_max) begin
            if (sec_lo_q != 4'd9) begin
                sec_lo_d = sec_lo_q + 4'd1;
            end else begin
                sec_lo_d = 4'd0;
                if (sec_hi_q != 4'd5) begin
                    sec_hi_d = sec_hi_q + 4'd1;
                end else begin
                    sec_hi_d = 4'd0;
                    if (min_lo_q != 4'd9) begin
                        min_lo_d = min_lo_q + 4'd1;
                    end else begin
                        min_lo_d = 4'd0;
                        min_hi_d = min_hi_q + 4'd1;
                    end
                end
            end
        end
    end

    // Digit registers with async reset and synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_lo_q <= '0;
            sec_hi_q <= '0;
            min_lo_q <= '0;
            min_hi_q <= '0;
        end else if (clr) begin
            sec_lo_q <= '0;
            sec_hi_q <= '0;
            min_lo_q <= '0;
            min_hi_q <= '0;
        end else begin
            sec_lo_q <= sec_lo_d;
            sec_hi_q <= sec_hi_d;
            min_lo_q <= min_lo_d;
            min_hi_q <= min_hi_d;
        end
    end

    assign min_bcd = {min_hi_q, min_lo_q};
    assign sec_bcd = {sec_hi_q, sec_lo_q};

endmodule

// File: rtl/wait_timer.sv
// Taxi waiting-time meter: emits one PULSE_W-wide billing pulse per UNIT_MIN waited minutes, MM:SS display.
// Latency: pulse rises on the edge after the terminal second tick; BCD time updates on the tick edge.
// Backpressure: none; optional free grace period enabled by defining WAIT_GRACE_EN.
module wait_timer
    import wait_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int UNIT_MIN  = 10,
    parameter int GRACE_MIN = 3,
    parameter int PULSE_W   = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wait_en,
    input  logic       max,
    output logic       wait_fare_pulse,
    output logic [7:0] wait_min_bcd,
    output logic [7:0] wait_sec_bcd,
    output logic       billing
);

    localparam int UNIT_SEC = UNIT_MIN * SEC_PER_MIN;
    localparam int PRE_W    = cnt_width(CLK_HZ);
    localparam int UNIT_W   = cnt_width(UNIT_SEC);
    localparam int PCNT_W   = cnt_width(PULSE_W);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_SEC - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_W - 1);

    wait_state_t        state_q, state_d;
    wait_state_t        resume_st;
    wait_state_t        act_st;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [UNIT_W-1:0]  unit_q, unit_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic               pulse_q, pulse_d;
    logic               run;
    logic               sec_tick;
    logic               unit_wrap;
    logic               grace_end;

    // Time only advances while waiting, not frozen, and not in the cycle max arrives,
    // so a max coinciding with a terminal tick suppresses that tick and its pulse.
    assign run      = wait_en && (state_q != ST_FULL) && !max;
    assign sec_tick = run && (presc_q == PRE_LAST);

    // The cycle wait_en returns the FSM is still IDLE; ticks in that cycle are credited
    // to the state being resumed so no second is lost across a stop.
    assign act_st = (state_q == ST_IDLE && wait_en) ? resume_st : state_q;

`ifdef WAIT_GRACE_EN
    localparam int GRACE_SEC = GRACE_MIN * SEC_PER_MIN;
    localparam int GR_W      = cnt_width(GRACE_SEC);
    localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRACE_SEC - 1);

    logic [GR_W-1:0] grace_q, grace_d;
    logic            grace_done_q, grace_done_d;

    assign grace_end = sec_tick && (act_st == ST_GRACE) && (grace_q == GR_LAST);
    assign resume_st = grace_done_q ? ST_BILL : ST_GRACE;

    // Grace seconds accumulate across stops; once used up they stay used for the trip.
    always_comb begin
        grace_d      = grace_q;
        grace_done_d = grace_done_q;
        if (sec_tick && act_st == ST_GRACE) begin
            grace_d = grace_end ? '0 : grace_q + 1'b1;
        end
        if (grace_end) begin
            grace_done_d = 1'b1;
        end
    end

    // Grace counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grace_q      <= '0;
            grace_done_q <= 1'b0;
        end else if (clr) begin
            grace_q      <= '0;
            grace_done_q <= 1'b0;
        end else begin
            grace_q      <= grace_d;
            grace_done_q <= grace_done_d;
        end
    end
`else
    assign grace_end = 1'b0;
    assign resume_st = ST_BILL;

    // GRACE_MIN has no effect without the grace feature; this empty block only references it.
    if (GRACE_MIN < 0) begin : g_grace_min_ignored
    end
`endif

    // Next state: FULL is absorbing (only rst/clr leave it), max beats everything else.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_FULL) begin
            if (max) begin
                state_d = ST_FULL;
            end else if (!wait_en) begin
                state_d = ST_IDLE;
            end else if (grace_end) begin
                state_d = ST_BILL;
            end else begin
                state_d = act_st;
            end
        end
    end

    assign unit_wrap = sec_tick && (act_st == ST_BILL) && (unit_q == UNIT_LAST);

    // Prescaler holds its partial second while stopped; pulse, once started, runs to completion.
    always_comb begin
        presc_d = presc_q;
        unit_d  = unit_q;
        pcnt_d  = pcnt_q;
        pulse_d = 1'b0;
        if (run) begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
        end
        if (sec_tick && act_st == ST_BILL) begin
            unit_d = unit_wrap ? '0 : unit_q + 1'b1;
        end
        if (unit_wrap) begin
            pcnt_d  = PCNT_LOAD;
            pulse_d = 1'b1;
        end else if (pcnt_q != '0) begin
            pcnt_d  = pcnt_q - 1'b1;
            pulse_d = 1'b1;
        end
    end

    // State, counters and the output pulse flop; clr outranks every other synchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            unit_q  <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            unit_q  <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            unit_q  <= unit_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
        end
    end

    bcd_mmss_cnt u_disp (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (sec_tick),
        .min_bcd (wait_min_bcd),
        .sec_bcd (wait_sec_bcd)
    );

    assign wait_fare_pulse = pulse_q;
    assign billing         = (state_q == ST_BILL);

endmodule

// File: tb/tb_wait_timer.sv
// Directed bench for wait_timer with CLK_HZ=4, UNIT_MIN=1, GRACE_MIN=1, PULSE_W=2.
// Latency: edges are counted from the first edge that sees wait_en high after reset/clear.
// Backpressure: n/a; expectations adapt to WAIT_GRACE_EN (one free minute shifts billing by 240 cycles).
module tb_wait_timer;

    localparam int CLK_HZ    = 4;
    localparam int UNIT_MIN  = 1;
    localparam int GRACE_MIN = 1;
    localparam int PULSE_W   = 2;

`ifdef WAIT_GRACE_EN
    localparam int G = 240;
`else
    localparam int G = 0;
`endif
    // Edge on which the first billing pulse becomes visible.
    localparam int          P          = 240 + G;
    localparam logic [15:0] T_P        = (G == 0) ? 16'h0100 : 16'h0200;
    localparam logic [15:0] T_PM1      = (G == 0) ? 16'h0059 : 16'h0159;
    localparam logic        EARLY_BILL = (G == 0);

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       wait_en;
    logic       max;
    logic       wait_fare_pulse;
    logic [7:0] wait_min_bcd;
    logic [7:0] wait_sec_bcd;
    logic       billing;

    int cyc;
    int n_chk;
    int n_fail;
    int hi_cnt;

    always #5 clk = ~clk;

    wait_timer #(
        .CLK_HZ    (CLK_HZ),
        .UNIT_MIN  (UNIT_MIN),
        .GRACE_MIN (GRACE_MIN),
        .PULSE_W   (PULSE_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clr             (clr),
        .wait_en         (wait_en),
        .max             (max),
        .wait_fare_pulse (wait_fare_pulse),
        .wait_min_bcd    (wait_min_bcd),
        .wait_sec_bcd    (wait_sec_bcd),
        .billing         (billing)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to edge t, sampling 1 time unit after each rising edge.
    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One clr edge, then waiting starts; edge numbering restarts at 0.
    task automatic restart();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr     = 1'b0;
        wait_en = 1'b1;
        cyc     = 0;
    endtask

    task automatic count_hi(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            go(cyc + 1);
            if (wait_fare_pulse) hi++;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        clr     = 1'b0;
        wait_en = 1'b0;
        max     = 1'b0;

        // Reset state
        #23;
        chk("rst_pulse", 16'(wait_fare_pulse), 16'h0);
        chk("rst_time", {wait_min_bcd, wait_sec_bcd}, 16'h0000);
        chk("rst_billing", 16'(billing), 16'h0);
        rst     = 1'b0;
        wait_en = 1'b1;
        cyc     = 0;

        // Continuous waiting from reset
        go(3);
        chk("s1_time_e3", {wait_min_bcd, wait_sec_bcd}, 16'h0000);
        go(4);
        chk("s1_time_e4", {wait_min_bcd, wait_sec_bcd}, 16'h0001);
        go(200);
        chk("s1_billing_e200", 16'(billing), 16'(EARLY_BILL));
        go(P - 1);
        chk("s1_pulse_pre", 16'(wait_fare_pulse), 16'h0);
        chk("s1_billing_pre", 16'(billing), 16'h1);
        chk("s1_time_pre", {wait_min_bcd, wait_sec_bcd}, T_PM1);
        go(P);
        chk("s1_pulse_rise", 16'(wait_fare_pulse), 16'h1);
        chk("s1_time_rise", {wait_min_bcd, wait_sec_bcd}, T_P);
        go(P + 1);
        chk("s1_pulse_2nd", 16'(wait_fare_pulse), 16'h1);
        go(P + 2);
        chk("s1_pulse_fall", 16'(wait_fare_pulse), 16'h0);
        go(P + 239);
        chk("s1_pulse2_pre", 16'(wait_fare_pulse), 16'h0);
        go(P + 240);
        chk("s1_pulse2_rise", 16'(wait_fare_pulse), 16'h1);

        // max during first pulse cycle: pulse completes, then everything freezes
        restart();
        go(P);
        chk("s2_pulse_rise", 16'(wait_fare_pulse), 16'h1);
        max = 1'b1;
        go(P + 1);
        chk("s2_pulse_held", 16'(wait_fare_pulse), 16'h1);
        chk("s2_billing_full", 16'(billing), 16'h0);
        go(P + 2);
        chk("s2_pulse_fall", 16'(wait_fare_pulse), 16'h0);
        count_hi(300, hi_cnt);
        chk("s2_no_pulses", 16'(hi_cnt), 16'h0);
        chk("s2_time_frozen", {wait_min_bcd, wait_sec_bcd}, T_P);
        chk("s2_billing_low", 16'(billing), 16'h0);
        max = 1'b0;
        go(cyc + 20);
        chk("s2_full_sticky", {wait_min_bcd, wait_sec_bcd}, T_P);
        restart();
        chk("s2_clr_time", {wait_min_bcd, wait_sec_bcd}, 16'h0000);
        chk("s2_clr_billing", 16'(billing), 16'h0);
        go(4);
        chk("s2_recount", {wait_min_bcd, wait_sec_bcd}, 16'h0001);

        // clr in the middle of a pulse
        restart();
        go(P);
        chk("s3_pulse_rise", 16'(wait_fare_pulse), 16'h1);
        clr = 1'b1;
        go(P + 1);
        chk("s3_pulse_killed", 16'(wait_fare_pulse), 16'h0);
        chk("s3_time_zero", {wait_min_bcd, wait_sec_bcd}, 16'h0000);
        chk("s3_billing_idle", 16'(billing), 16'h0);
        clr = 1'b0;
        cyc = 0;

        // 100-cycle stop at 00:30 with two prescaler counts already banked
        go(122);
        chk("s4_time_stop", {wait_min_bcd, wait_sec_bcd}, 16'h0030);
        wait_en = 1'b0;
        go(123);
        chk("s4_billing_stop", 16'(billing), 16'h0);
        go(222);
        chk("s4_time_hold", {wait_min_bcd, wait_sec_bcd}, 16'h0030);
        chk("s4_pulse_hold", 16'(wait_fare_pulse), 16'h0);
        wait_en = 1'b1;
        go(223);
        chk("s4_time_e223", {wait_min_bcd, wait_sec_bcd}, 16'h0030);
        go(224);
        chk("s4_partial_kept", {wait_min_bcd, wait_sec_bcd}, 16'h0031);
        chk("s4_billing_resume", 16'(billing), 16'(EARLY_BILL));
        go(P + 99);
        chk("s4_pulse_pre", 16'(wait_fare_pulse), 16'h0);
        go(P + 100);
        chk("s4_pulse_rise", 16'(wait_fare_pulse), 16'h1);
        chk("s4_time_rise", {wait_min_bcd, wait_sec_bcd}, T_P);

        // max arriving on the terminal tick cycle wins: no pulse, no tick
        restart();
        go(P - 1);
        chk("s5_time_pre", {wait_min_bcd, wait_sec_bcd}, T_PM1);
        max = 1'b1;
        go(P);
        chk("s5_no_pulse", 16'(wait_fare_pulse), 16'h0);
        go(P + 2);
        chk("s5_still_no_pulse", 16'(wait_fare_pulse), 16'h0);
        chk("s5_time_frozen", {wait_min_bcd, wait_sec_bcd}, T_PM1);
        chk("s5_billing", 16'(billing), 16'h0);
        max = 1'b0;

        // Long wait: display saturates at 99:59 while billing carries on
        restart();
        go(23995);
        chk("s6_time_9958", {wait_min_bcd, wait_sec_bcd}, 16'h9958);
        go(23996);
        chk("s6_time_9959", {wait_min_bcd, wait_sec_bcd}, 16'h9959);
        go(24100);
        chk("s6_time_sat", {wait_min_bcd, wait_sec_bcd}, 16'h9959);
        count_hi(480, hi_cnt);
        chk("s6_pulse_cycles", 16'(hi_cnt), 16'h4);
        chk("s6_time_sat_end", {wait_min_bcd, wait_sec_bcd}, 16'h9959);
        chk("s6_billing", 16'(billing), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
